// File: rtl/laser_pkg.sv
// rtl/laser_pkg.sv - shared widths, word type and limits for the laser receive path
package laser_pkg;

    localparam int LASER_BYTE_W = 8;

    typedef logic [2*LASER_BYTE_W-1:0] laser_word_t;

    localparam logic [7:0] DROP_MAX = 8'd255;

endpackage : laser_pkg

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - single-cycle pulse on the 0->1 transition of a level
// Ports:
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   in      : level input
//   rise    : high for the one cycle where in=1 and its previous sample was 0
module rise_detect #(
    // Seeding the history register with 1 suppresses a pulse for a level
    // that is already high when reset is released.
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in,
    output logic rise
);

    logic in_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_q <= RESET_VAL;
        end else begin
            in_q <= in;
        end
    end

    assign rise = in & ~in_q;

endmodule : rise_detect

// File: rtl/laser_rx_fifo.sv
// rtl/laser_rx_fifo.sv - first-word-fall-through buffer for LaserReceiver byte pairs
// Ports:
//   clock, reset_n                 : system clock, asynchronous active-low reset
//   data_valid, data1_in, data2_in : receiver word, queued on the rise of data_valid
//   clear                          : synchronous flush of contents, flags and counters
//   rd_en, rd_data, empty          : FWFT read port; rd_data is 0 while empty
//   full, count                    : occupancy, 0..DEPTH
//   overflow, drop_count           : sticky drop flag, drop counter saturating at 255
//   last_word                      : most recent accepted word, for display
module laser_rx_fifo
    import laser_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    data_valid,
    input  logic [LASER_BYTE_W-1:0] data1_in,
    input  logic [LASER_BYTE_W-1:0] data2_in,
    input  logic                    clear,
    input  logic                    rd_en,
    output laser_word_t             rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [CW-1:0]           count,
    output logic                    overflow,
    output logic [7:0]              drop_count,
    output laser_word_t             last_word
);

    localparam int AW = CW - 1;

    laser_word_t   mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;

    logic push;
    logic do_pop;
    logic do_push;
    logic do_drop;

    laser_word_t in_word;

    // Reset value 1: a data_valid already high at reset release is not a new word.
    rise_detect #(
        .RESET_VAL (1'b1)
    ) u_valid_rise (
        .clock   (clock),
        .reset_n (reset_n),
        .in      (data_valid),
        .rise    (push)
    );

    assign in_word = {data1_in, data2_in};

    // Pointers carry one extra wrap bit so that full and empty are
    // distinguishable and the difference is directly the occupancy.
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == CW'(DEPTH));

    // A pop in the same cycle frees the head slot, so a push into a full
    // buffer is only dropped when no pop accompanies it.
    assign do_pop  = rd_en & ~empty & ~clear;
    assign do_push = push & (~full | do_pop) & ~clear;
    assign do_drop = push & full & ~do_pop & ~clear;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            last_word  <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            last_word  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            if (do_push) begin
                wr_ptr    <= wr_ptr + CW'(1);
                last_word <= in_word;
            end
            if (do_drop) begin
                overflow <= 1'b1;
                if (drop_count != DROP_MAX) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

    // Storage is deliberately left without reset; only the pointers define
    // which entries are meaningful.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= in_word;
        end
    end

    assign rd_data = empty ? laser_word_t'(0) : mem[rd_ptr[AW-1:0]];

endmodule : laser_rx_fifo

// File: doc/laser_rx_fifo.md
Name: laser_rx_fifo

Overview:
- Receive-side buffer directly downstream of LaserReceiver.
- Captures each new byte pair {data1_in, data2_in} on the rising edge of the receiver's data_valid and queues it as one 16-bit word.
- Exposes a first-word-fall-through read port to the host-facing logic.
- Tracks occupancy, a sticky overflow flag, a saturating drop counter and the most recent received word for HEX display.

Parameters:
- DEPTH, 16, number of 16-bit word entries; must be a power of 2 and at least 2.
- CW, $clog2(DEPTH)+1, width of the count output; derived, not overridden.

Ports:
- clock  input  1  system clock (50 MHz, same domain as LaserReceiver)
- reset_n  input  1  asynchronous active-low reset
- data_valid  input  1  receiver valid level; a new word is signalled by its 0->1 transition
- data1_in  input  8  laser 1 byte, forms word bits [15:8]
- data2_in  input  8  laser 2 byte, forms word bits [7:0]
- clear  input  1  synchronous flush of contents, flags and counters
- rd_en  input  1  pop the head word; ignored when empty
- rd_data  output  16  head word, valid whenever empty=0
- empty  output  1  no words stored
- full  output  1  count == DEPTH
- count  output  CW  words stored, 0..DEPTH
- overflow  output  1  sticky; set when a word was dropped
- drop_count  output  8  number of dropped words, saturates at 255
- last_word  output  16  most recent accepted word, for display

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Pointers and count = 0; empty=1, full=0.
  - overflow=0, drop_count=0, last_word=16'h0000, rd_data=16'h0000.
  - Edge register valid_q=1, so a data_valid held high across reset release does not push.
  - Storage array contents are not reset.
- Edge detect:
  - push = data_valid & ~valid_q.
  - valid_q <= data_valid on every clock.
  - A level held high for N cycles yields exactly one push.
- Push (clock edge with push=1, clear=0):
  - Not full: mem[wr_ptr] <= {data1_in, data2_in}; wr_ptr increments with modulo DEPTH wrap; last_word updated.
  - Latency: empty deasserts and rd_data shows the word on the cycle after the push edge.
- Pop (rd_en=1, empty=0, clear=0):
  - rd_ptr increments with modulo wrap.
  - rd_data is the combinational read of mem[rd_ptr] (FWFT); it shows the next word immediately after the edge.
  - rd_data is 16'h0000 when empty.
- Simultaneous push and pop:
  - Not full and not empty: both occur, count unchanged.
  - Full: the pop frees a slot and the push is accepted (no drop); count stays DEPTH.
  - Empty: the pop is ignored and the push is accepted; count becomes 1.
- Overflow:
  - Push while full with no valid pop: word discarded, overflow <= 1.
  - drop_count increments, holding at 255.
  - last_word is not updated; pointers are unchanged.
- clear (synchronous, highest priority after reset):
  - Pointers, count, overflow and drop_count <= 0; last_word <= 0.
  - A push or pop in the same cycle is ignored.
  - valid_q still tracks data_valid.
- full, empty and count are derived from registered state; count = wr_ptr - rd_ptr using CW-bit pointers with an extra wrap bit.
- Reset mid-operation: all state returns to reset values immediately, and any stored words are lost.

Decomposition:
- Shared package laser_pkg:
  - LASER_BYTE_W = 8
  - typedef laser_word_t (logic [15:0])
  - constant DROP_MAX = 8'd255
- Sub-module rise_detect (clock, reset_n, in, rise), with a reset-value parameter for its internal register; instantiated once for data_valid.
- The FIFO storage and pointers stay inline.

Test Plan:
- Reset release with data_valid=1 held -> no push, empty=1, count=0; then data_valid 0->1 with bytes 8'h08/8'hFF -> next cycle rd_data=16'h08FF, count=1, last_word=16'h08FF.
- data_valid held high 10 cycles with changing bytes -> exactly one word stored, equal to the bytes present on the first high cycle.
- 16 pushes 16'h0100..16'h010F, then a 17th push 16'hDEAD -> full=1, overflow=1, drop_count=1, last_word=16'h010F; 16 pops return 16'h0100..16'h010F in order, then empty=1.
- Full FIFO with push and rd_en in the same cycle -> no drop, count=16, head advances, new word at the tail; with the FIFO empty, push plus rd_en -> count=1.
- 300 pushes into a full FIFO with no pops -> drop_count saturates at 255, overflow=1; clear -> count=0, overflow=0, drop_count=0, empty=1.
- Pointer wrap: 40 interleaved push/pop pairs with incrementing data -> every read matches the write order across 2+ wraps; reset_n pulsed low mid-stream -> immediate empty=1, count=0.
